// File: rtl/scheduler_pkg.sv
// Shared scheduler types: slot indices/masks, age matrix, arbiter FSM states,
// watchdog limit and a one-hot helper.
package scheduler_pkg;

  localparam int SLOT_COUNT = 8;

  typedef logic [2:0]                             slot_idx_t;
  typedef logic [SLOT_COUNT-1:0]                  slot_mask_t;
  typedef logic [SLOT_COUNT-1:0][SLOT_COUNT-1:0]  slot_age_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic [7:0] WD_LIMIT = 8'd255;

  function automatic slot_mask_t slot_onehot(input slot_idx_t idx);
    return slot_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_issue_arbiter_if.sv
// Slot-request and memory-port handshake bundle for mem_issue_arbiter.
// master = arbiter side, slave = slots/memory unit side.
interface mem_issue_arbiter_if;
  import scheduler_pkg::*;

  slot_mask_t slot_req;
  slot_age_t  slot_older;
  logic       flush;
  logic       mem_req_valid;
  logic       mem_req_ready;
  slot_idx_t  mem_req_slot;
  logic       mem_done;
  slot_mask_t slot_done;
  logic       busy;
  logic       watchdog_err;

  modport master (
    input  slot_req, slot_older, flush, mem_req_ready, mem_done,
    output mem_req_valid, mem_req_slot, slot_done, busy, watchdog_err
  );

  modport slave (
    output slot_req, slot_older, flush, mem_req_ready, mem_done,
    input  mem_req_valid, mem_req_slot, slot_done, busy, watchdog_err
  );

endinterface

// File: rtl/oldest_slot_select.sv
// Picks the oldest requesting slot from the age matrix; a cyclic or otherwise
// inconsistent matrix falls back to the lowest requesting index.
module oldest_slot_select
  import scheduler_pkg::*;
(
  input  slot_mask_t req_mask,
  input  slot_age_t  age,
  output slot_idx_t  sel_idx,
  output logic       sel_found
);

  slot_mask_t cand;

  // A slot is a candidate when no other requester claims to be older than it.
  always_comb begin
    cand = req_mask;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      for (int j = 0; j < SLOT_COUNT; j++) begin
        if (j != i && req_mask[j] && age[j][i]) cand[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = |req_mask;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (req_mask[i]) sel_idx = slot_idx_t'(i);
    end
    if (|cand) begin
      for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
        if (cand[i]) sel_idx = slot_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/mem_issue_arbiter.sv
// Issues the oldest requesting slot to the shared memory port, one access at a
// time. Optional watchdog: define MEM_ISSUE_ARBITER_WATCHDOG_EN.
//
// state    | meaning
// ST_IDLE  | no access outstanding; select oldest requester
// ST_ISSUE | mem_req_valid high, waiting for mem_req_ready
// ST_WAIT  | request accepted, waiting for mem_done
module mem_issue_arbiter
  import scheduler_pkg::*;
(
  input logic                 main_clk,
  input logic                 main_rst_n,
  mem_issue_arbiter_if.master bus
);

  arb_state_t state_q, state_d;
  slot_idx_t  slot_q, slot_d;
  logic       kill_q, kill_d;
  slot_idx_t  sel_idx;
  logic       sel_found;

  oldest_slot_select u_select (
    .req_mask  (bus.slot_req),
    .age       (bus.slot_older),
    .sel_idx   (sel_idx),
    .sel_found (sel_found)
  );

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      kill_q  <= kill_d;
    end
  end

  // A flushed access still finishes its handshake; kill_q only suppresses slot_done.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    kill_d  = kill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found && !bus.flush) begin
          slot_d  = sel_idx;
          kill_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.mem_done) begin
          kill_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = (state_q == ST_ISSUE);
    bus.mem_req_slot  = slot_q;
    bus.busy          = (state_q != ST_IDLE);
    bus.slot_done     = '0;
    if (state_q == ST_WAIT && bus.mem_done && !kill_q && !bus.flush)
      bus.slot_done = slot_onehot(slot_q);
  end

`ifdef MEM_ISSUE_ARBITER_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       wd_err_q, wd_err_d;

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  // Counter saturates at the limit; the error flag is sticky until reset.
  always_comb begin
    wd_cnt_d = '0;
    wd_err_d = wd_err_q;
    if (state_q == ST_WAIT && !bus.mem_done) begin
      wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 8'd1;
      if (wd_cnt_d == WD_LIMIT) wd_err_d = 1'b1;
    end
  end

  assign bus.watchdog_err = wd_err_q;
`else
  assign bus.watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_issue_arbiter.sv
// Directed bench for mem_issue_arbiter: table-driven age-selection vectors plus
// hand-written reset, backpressure, flush, back-to-back and watchdog sequences.
module tb_mem_issue_arbiter;
  import scheduler_pkg::*;

  logic main_clk = 1'b0;
  logic main_rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_issue_arbiter_if bus_if ();

  mem_issue_arbiter dut (
    .main_clk   (main_clk),
    .main_rst_n (main_rst_n),
    .bus        (bus_if)
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    logic [7:0]  req;
    logic [63:0] older;
    logic [2:0]  exp_slot;
  } sel_vec_t;

  sel_vec_t tv[9];

`ifdef MEM_ISSUE_ARBITER_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  function automatic logic [63:0] ob(input int j, input int i);
    return 64'd1 << (j * 8 + i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge main_clk);
    #1;
  endtask

  task automatic idle_outputs(input string name);
    chk({name, "_valid"}, 32'(bus_if.mem_req_valid), 32'd0);
    chk({name, "_busy"}, 32'(bus_if.busy), 32'd0);
    chk({name, "_done"}, 32'(bus_if.slot_done), 32'd0);
  endtask

  // Request slot mask req (no age ordering) and leave the FSM in WAIT.
  task automatic go_wait(input logic [7:0] req);
    @(negedge main_clk);
    bus_if.slot_req = req;
    at_pos();
    @(negedge main_clk);
    bus_if.slot_req = '0;
    bus_if.mem_req_ready = 1'b1;
    at_pos();
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b0;
  endtask

  initial begin
    bus_if.slot_req = '0;
    bus_if.slot_older = '0;
    bus_if.flush = 1'b0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_done = 1'b0;

    tv[0] = '{8'h24, ob(5, 2), 3'd5};
    tv[1] = '{8'h01, 64'd0, 3'd0};
    tv[2] = '{8'h81, 64'd0, 3'd0};
    tv[3] = '{8'h81, ob(7, 0), 3'd7};
    tv[4] = '{8'hF0, ob(6, 4) | ob(6, 5) | ob(6, 7) | ob(4, 7), 3'd6};
    tv[5] = '{8'h0C, ob(2, 3) | ob(3, 2), 3'd2};
    tv[6] = '{8'h0C, ob(3, 2), 3'd3};
    tv[7] = '{8'h02, ob(1, 1), 3'd1};
    tv[8] = '{8'h88, ob(7, 3) | ob(0, 7), 3'd7};

    // Reset held, then released with no requests.
    repeat (3) @(posedge main_clk);
    #1;
    idle_outputs("rst_held");
    chk("rst_slot", 32'(bus_if.mem_req_slot), 32'd0);
    chk("rst_wd", 32'(bus_if.watchdog_err), 32'd0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      at_pos();
      idle_outputs("idle10");
    end

    // Age selection table.
    for (int v = 0; v < 9; v++) begin
      @(negedge main_clk);
      bus_if.slot_req = tv[v].req;
      bus_if.slot_older = tv[v].older;
      #1 chk("sel_lat0", 32'(bus_if.mem_req_valid), 32'd0);
      at_pos();
      chk("sel_valid", 32'(bus_if.mem_req_valid), 32'd1);
      chk("sel_slot", 32'(bus_if.mem_req_slot), 32'(tv[v].exp_slot));
      @(negedge main_clk);
      bus_if.slot_req = '0;
      bus_if.mem_req_ready = 1'b1;
      at_pos();
      chk("sel_wait_busy", 32'(bus_if.busy), 32'd1);
      chk("sel_wait_valid", 32'(bus_if.mem_req_valid), 32'd0);
      @(negedge main_clk);
      bus_if.mem_req_ready = 1'b0;
      bus_if.mem_done = 1'b1;
      #1 chk("sel_slot_done", 32'(bus_if.slot_done), 32'(8'd1 << tv[v].exp_slot));
      at_pos();
      chk("sel_idle_busy", 32'(bus_if.busy), 32'd0);
      chk("sel_done_gone", 32'(bus_if.slot_done), 32'd0);
      @(negedge main_clk);
      bus_if.mem_done = 1'b0;
    end
    bus_if.slot_older = '0;

    // Backpressure: ready low 6 cycles, mem_done in ISSUE ignored.
    @(negedge main_clk);
    bus_if.slot_req = 8'h10;
    at_pos();
    @(negedge main_clk);
    bus_if.slot_req = '0;
    bus_if.mem_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp_valid", 32'(bus_if.mem_req_valid), 32'd1);
      chk("bp_slot", 32'(bus_if.mem_req_slot), 32'd4);
      chk("bp_no_done", 32'(bus_if.slot_done), 32'd0);
      @(negedge main_clk);
      bus_if.mem_done = 1'b0;
    end
    bus_if.mem_req_ready = 1'b1;
    at_pos();
    chk("bp_wait_valid", 32'(bus_if.mem_req_valid), 32'd0);
    chk("bp_wait_busy", 32'(bus_if.busy), 32'd1);
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_done = 1'b1;
    #1 chk("bp_slot_done", 32'(bus_if.slot_done), 32'h10);
    at_pos();
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;

    // Flush in ISSUE: handshake completes, completion suppressed.
    @(negedge main_clk);
    bus_if.slot_req = 8'h02;
    at_pos();
    @(negedge main_clk);
    bus_if.slot_req = '0;
    bus_if.flush = 1'b1;
    at_pos();
    chk("fl_issue_valid", 32'(bus_if.mem_req_valid), 32'd1);
    @(negedge main_clk);
    bus_if.flush = 1'b0;
    at_pos();
    chk("fl_issue_hold", 32'(bus_if.mem_req_valid), 32'd1);
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b1;
    at_pos();
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b0;
    repeat (2) @(negedge main_clk);
    bus_if.mem_done = 1'b1;
    #1 chk("fl_issue_nodone", 32'(bus_if.slot_done), 32'd0);
    at_pos();
    chk("fl_issue_idle", 32'(bus_if.busy), 32'd0);
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;

    // Flush in IDLE suppresses selection that cycle.
    @(negedge main_clk);
    bus_if.slot_req = 8'h08;
    bus_if.flush = 1'b1;
    at_pos();
    idle_outputs("fl_idle");
    @(negedge main_clk);
    bus_if.flush = 1'b0;
    at_pos();
    chk("fl_idle_valid", 32'(bus_if.mem_req_valid), 32'd1);
    chk("fl_idle_slot", 32'(bus_if.mem_req_slot), 32'd3);

    // Back-to-back with slot_req held; flush coinciding with mem_done kills it.
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b1;
    at_pos();
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_done = 1'b1;
    bus_if.flush = 1'b1;
    #1 chk("fl_wait_nodone", 32'(bus_if.slot_done), 32'd0);
    at_pos();
    chk("b2b_t1_valid", 32'(bus_if.mem_req_valid), 32'd0);
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;
    bus_if.flush = 1'b0;
    at_pos();
    chk("b2b_t2_valid", 32'(bus_if.mem_req_valid), 32'd1);
    @(negedge main_clk);
    bus_if.slot_req = '0;
    bus_if.mem_req_ready = 1'b1;
    at_pos();
    @(negedge main_clk);
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_done = 1'b1;
    #1 chk("b2b_slot_done", 32'(bus_if.slot_done), 32'h08);
    at_pos();
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;

    // Reset pulsed mid-WAIT; a later mem_done is ignored.
    go_wait(8'h20);
    chk("rw_busy_pre", 32'(bus_if.busy), 32'd1);
    #2 main_rst_n = 1'b0;
    #1;
    idle_outputs("rw_async");
    chk("rw_slot", 32'(bus_if.mem_req_slot), 32'd0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    bus_if.mem_done = 1'b1;
    #1;
    idle_outputs("rw_done_ign");
    at_pos();
    idle_outputs("rw_after");
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;

    // Watchdog: long WAIT without mem_done.
    go_wait(8'h40);
    repeat (200) @(posedge main_clk);
    #1 chk("wd_early", 32'(bus_if.watchdog_err), 32'd0);
    repeat (60) @(posedge main_clk);
    #1 chk("wd_err", 32'(bus_if.watchdog_err), 32'(WD_EXP));
    chk("wd_still_wait", 32'(bus_if.busy), 32'd1);
    @(negedge main_clk);
    bus_if.mem_done = 1'b1;
    #1 chk("wd_slot_done", 32'(bus_if.slot_done), 32'h40);
    at_pos();
    chk("wd_sticky", 32'(bus_if.watchdog_err), 32'(WD_EXP));
    chk("wd_idle", 32'(bus_if.busy), 32'd0);
    @(negedge main_clk);
    bus_if.mem_done = 1'b0;
    main_rst_n = 1'b0;
    #1 chk("wd_cleared", 32'(bus_if.watchdog_err), 32'd0);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    at_pos();
    idle_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // slot_done must never have more than one bit set.
  always @(negedge main_clk) begin
    if (main_rst_n && !$onehot0(bus_if.slot_done)) begin
      n_cmp++;
      n_err++;
      $display("FAIL slot_done_onehot: got %0h expected zero or one-hot", bus_if.slot_done);
    end
  end

endmodule

// File: doc/mem_issue_arbiter.md
MEM_ISSUE_ARBITER -- requirements
Module: mem_issue_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is main_clk and the reset is main_rst_n, asynchronous and active-low.
REQ-002 main_clk  input  1  core clock; all state updates on its rising edge.
REQ-003 main_rst_n  input  1  asynchronous active-low reset.
REQ-004 slot_req  input  8  bit i high = instruction slot i requests the shared memory port.
REQ-005 slot_older  input  8x8  slot_older[i][j] high = slot i is older than slot j; diagonal ignored.
REQ-006 flush  input  1  jump flush; kills any in-flight or pending access.
REQ-007 mem_req_valid  output  1  request to memory unit.
REQ-008 mem_req_ready  input  1  memory unit accepts request when high with mem_req_valid.
REQ-009 mem_req_slot  output  3  slot index of the current request.
REQ-010 mem_done  input  1  one-cycle completion pulse for the accepted request.
REQ-011 slot_done  output  8  one-hot completion pulse to the owning slot.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 watchdog_err  output  1  sticky watchdog error flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-015 In IDLE with any slot_req bit high and flush low, the FSM SHALL latch the oldest requesting slot into slot_q and go to ISSUE; mem_req_valid rises on the following cycle (1-cycle latency).
REQ-016 The oldest requesting slot SHALL be the requesting slot i such that no other requesting j has slot_older[j][i] high; ties or inconsistent matrices resolve to the lowest such index; with no such slot, the lowest requesting index wins.
REQ-017 In ISSUE, mem_req_valid SHALL be high and mem_req_slot SHALL equal slot_q, both held stable until mem_req_ready is high, then the FSM goes to WAIT.
REQ-018 In IDLE and WAIT, mem_req_valid SHALL be low.
REQ-019 flush in ISSUE SHALL NOT drop mem_req_valid; it SHALL set kill_q, and the request completes its handshake normally.
REQ-020 flush in WAIT SHALL set kill_q.
REQ-021 In WAIT on mem_done, slot_done[slot_q] SHALL pulse combinationally in the same cycle unless kill_q or flush is high; the FSM then returns to IDLE and clears kill_q.
REQ-022 mem_done outside WAIT SHALL be ignored.
REQ-023 Flush in IDLE SHALL suppress selection for that cycle.
REQ-024 A new request SHALL NOT be issued before the previous mem_done; the earliest back-to-back mem_req_valid is 2 cycles after mem_done.
REQ-025 slot_done SHALL be zero or one-hot at all times.

Reset
REQ-026 Assertion of main_rst_n low SHALL force state IDLE, slot_q=0, kill_q=0, watchdog counter 0, watchdog_err=0, mem_req_valid=0, mem_req_slot=0, slot_done=0 and busy=0 immediately, including mid-transaction.
REQ-027 After reset deassertion, the first selection SHALL occur on the first rising edge with slot_req nonzero.

Configuration
REQ-028 Macro MEM_ISSUE_ARBITER_WATCHDOG_EN defined: an 8-bit counter SHALL increment each cycle in WAIT and clear on leaving WAIT; on reaching 255 without mem_done, watchdog_err SHALL set and remain high until reset, and the FSM SHALL remain in WAIT.
REQ-029 Macro MEM_ISSUE_ARBITER_WATCHDOG_EN undefined: no counter SHALL exist, and watchdog_err SHALL be tied 0 with the port kept.

Structure
REQ-030 Shared package scheduler_pkg SHALL hold SLOT_COUNT=8, slot_idx_t (3-bit), slot_mask_t (8-bit), the FSM state enum and the watchdog limit constant 255.
REQ-031 The combinational oldest-request selection SHALL be the sub-module oldest_slot_select (inputs: request mask and age matrix; outputs: index and found flag).

Verification
REQ-032 Reset scenario: slot_req=8'h00 after reset -> mem_req_valid=0, busy=0, slot_done=0 for 10 cycles.
REQ-033 Age selection scenario: slot_req=8'h24, slot_older[5][2]=1 -> mem_req_slot=5 one cycle later; ready=1 then done=1 -> slot_done=8'h20 in the done cycle.
REQ-034 Backpressure scenario: mem_req_ready held low 6 cycles -> mem_req_valid and mem_req_slot stable all 6 cycles; WAIT entered on cycle 7.
REQ-035 Flush in ISSUE scenario: flush in ISSUE, ready 2 cycles later, done 3 cycles after that -> handshake completes, slot_done stays 0, FSM returns to IDLE.
REQ-036 Reset mid-WAIT scenario: main_rst_n pulsed low while in WAIT -> all outputs 0 asynchronously; a later mem_done is ignored.
REQ-037 Watchdog scenario (macro defined): mem_done withheld 255 cycles in WAIT -> watchdog_err=1, sticky through subsequent mem_done until reset.
